// File: rtl/id_decode.sv
// id_decode: MIPS instruction decode/issue stage feeding the ALU.
//   Decodes one 32-bit instruction per in_valid/in_ready handshake, reads the
//   register file combinationally and registers the ALU bundle (alu_a, alu_b,
//   alu_op, wb_en, wb_dst, ov_check) toward EX on an out_valid/out_ready
//   handshake. A 32-entry busy scoreboard stalls read-after-write hazards
//   until writeback (wb_valid/wb_addr) retires the producer.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_instr     instruction input;  in_ready accept strobe
//   rf_raddr1/rf_raddr2   register-file read addresses (rs, rt)
//   rf_rdata1/rf_rdata2   asynchronous register-file read data
//   wb_valid/wb_addr      writeback retirement (clears busy bit)
//   out_valid/out_ready   EX-side handshake
//   alu_a/alu_b/alu_op    registered operands and ALU operation
//   wb_en/wb_dst          destination of the issued instruction
//   ov_check              EX must trap on signed overflow
//   dec_illegal           only with ID_ILLEGAL_TRAP_EN defined
// Build option: ID_ILLEGAL_TRAP_EN -- unrecognised encodings issue as a trap
//   (alu_op 11111, dec_illegal=1); otherwise they issue as a NOP.
module id_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        wb_en,
  output logic [4:0]  wb_dst,
  output logic        ov_check
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic        dec_illegal
`endif
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b01000;
  localparam logic [4:0] OP_NOR = 5'b10000;
  localparam logic [4:0] OP_XOR = 5'b11000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_SLT = 5'b01010;
  localparam logic [4:0] OP_SRL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b01100;
  localparam logic [4:0] OP_SLL = 5'b10100;
  localparam logic [4:0] OP_LUI = 5'b11100;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic [4:0] OP_ILL = 5'b11111;
`endif

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign shamt  = in_instr[10:6];
  assign funct  = in_instr[5:0];
  assign imm    = in_instr[15:0];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Instruction format flags; exactly one is set for a recognised encoding.
  logic       f_alu_r, f_sh_imm, f_sh_var, f_imm_s, f_imm_z, f_lui, shl_left;
  logic       legal;
  logic [4:0] d_op, op_issue, d_dst, amt;
  logic [31:0] d_a, d_b;
  logic       d_ov, d_use_rs, d_use_rt, d_wb_en;

  always_comb begin
    f_alu_r  = 1'b0;
    f_sh_imm = 1'b0;
    f_sh_var = 1'b0;
    f_imm_s  = 1'b0;
    f_imm_z  = 1'b0;
    f_lui    = 1'b0;
    shl_left = 1'b0;
    d_ov     = 1'b0;
    d_op     = OP_AND;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000: begin d_op = OP_ADD; d_ov = 1'b1; f_alu_r = 1'b1; end
        6'b100001: begin d_op = OP_ADD; f_alu_r = 1'b1; end
        6'b100010: begin d_op = OP_SUB; d_ov = 1'b1; f_alu_r = 1'b1; end
        6'b100011: begin d_op = OP_SUB; f_alu_r = 1'b1; end
        6'b100100: begin d_op = OP_AND; f_alu_r = 1'b1; end
        6'b100101: begin d_op = OP_OR;  f_alu_r = 1'b1; end
        6'b100110: begin d_op = OP_XOR; f_alu_r = 1'b1; end
        6'b100111: begin d_op = OP_NOR; f_alu_r = 1'b1; end
        6'b101010: begin d_op = OP_SLT; f_alu_r = 1'b1; end
        6'b000000: begin d_op = OP_SLL; f_sh_imm = 1'b1; shl_left = 1'b1; end
        6'b000010: begin d_op = OP_SRL; f_sh_imm = 1'b1; end
        6'b000011: begin d_op = OP_SRA; f_sh_imm = 1'b1; end
        6'b000100: begin d_op = OP_SLL; f_sh_var = 1'b1; shl_left = 1'b1; end
        6'b000110: begin d_op = OP_SRL; f_sh_var = 1'b1; end
        6'b000111: begin d_op = OP_SRA; f_sh_var = 1'b1; end
        default: ;
      endcase
    end else begin
      case (opcode)
        6'b001000: begin d_op = OP_ADD; d_ov = 1'b1; f_imm_s = 1'b1; end
        6'b001001: begin d_op = OP_ADD; f_imm_s = 1'b1; end
        6'b001010: begin d_op = OP_SLT; f_imm_s = 1'b1; end
        6'b001100: begin d_op = OP_AND; f_imm_z = 1'b1; end
        6'b001101: begin d_op = OP_OR;  f_imm_z = 1'b1; end
        6'b001110: begin d_op = OP_XOR; f_imm_z = 1'b1; end
        6'b001111: begin d_op = OP_LUI; f_lui   = 1'b1; end
        default: ;
      endcase
    end
  end

  assign legal = f_alu_r | f_sh_imm | f_sh_var | f_imm_s | f_imm_z | f_lui;

  // Operand placement; the ALU's left shifter takes its amount in bits 10:6.
  always_comb begin
    d_a      = '0;
    d_b      = '0;
    d_dst    = '0;
    d_use_rs = 1'b0;
    d_use_rt = 1'b0;
    amt      = f_sh_imm ? shamt : rf_rdata1[4:0];
    if (f_alu_r) begin
      d_a      = rf_rdata1;
      d_b      = rf_rdata2;
      d_dst    = rd;
      d_use_rs = 1'b1;
      d_use_rt = 1'b1;
    end
    if (f_sh_imm || f_sh_var) begin
      d_a      = shl_left ? {21'b0, amt, 6'b0} : {27'b0, amt};
      d_b      = rf_rdata2;
      d_dst    = rd;
      d_use_rs = f_sh_var;
      d_use_rt = 1'b1;
    end
    if (f_imm_s || f_imm_z) begin
      d_a      = rf_rdata1;
      d_b      = f_imm_s ? {{16{imm[15]}}, imm} : {16'b0, imm};
      d_dst    = rt;
      d_use_rs = 1'b1;
    end
    if (f_lui) begin
      d_b   = {16'b0, imm};
      d_dst = rt;
    end
  end

  assign d_wb_en = legal && (d_dst != 5'd0);

`ifdef ID_ILLEGAL_TRAP_EN
  assign op_issue = legal ? d_op : OP_ILL;
`else
  assign op_issue = d_op;
`endif

  // Scoreboard. Hazard uses the registered busy bits, so a same-cycle
  // writeback clear only unblocks the instruction on the following cycle.
  logic [31:0] busy, busy_next;
  logic        hazard, accept;

  assign hazard   = (d_use_rs && busy[rs]) || (d_use_rt && busy[rt]);
  assign in_ready = !reset && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_next = busy;
    if (wb_valid)
      busy_next[wb_addr] = 1'b0;
    if (accept && d_wb_en)
      busy_next[d_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      wb_en       <= 1'b0;
      wb_dst      <= '0;
      ov_check    <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      dec_illegal <= 1'b0;
`endif
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_a       <= d_a;
      alu_b       <= d_b;
      alu_op      <= op_issue;
      wb_en       <= d_wb_en;
      wb_dst      <= d_dst;
      ov_check    <= d_ov;
`ifdef ID_ILLEGAL_TRAP_EN
      dec_illegal <= !legal;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode.sv
// tb_id_decode: self-checking bench for id_decode. A directed vector table,
// hand-written hazard/backpressure/reset sequences and a randomized phase are
// all checked against a mnemonic-level reference model and a scoreboard model.
module tb_id_decode;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, wb_valid, out_valid, out_ready;
  logic [31:0] in_instr, rf_rdata1, rf_rdata2, alu_a, alu_b;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_addr, alu_op, wb_dst;
  logic        wb_en, ov_check;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        dec_illegal;
  localparam logic [4:0] ILL_OP = 5'b11111;
`else
  localparam logic [4:0] ILL_OP = 5'b00000;
`endif

  id_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .wb_en(wb_en),
    .wb_dst(wb_dst), .ov_check(ov_check)
`ifdef ID_ILLEGAL_TRAP_EN
    , .dec_illegal(dec_illegal)
`endif
  );

  logic [31:0] regs [32];
  always_comb begin
    rf_rdata1 = regs[rf_raddr1];
    rf_rdata2 = regs[rf_raddr2];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wben;
    logic        ov;
    logic        ill;
    logic        use_rs;
    logic        use_rt;
  } ref_t;

  function automatic string mnem(input logic [31:0] i);
    logic [5:0] opc, fn;
    opc = i[31:26];
    fn  = i[5:0];
    if (opc == 6'h00) begin
      case (fn)
        6'h20: return "ADD";   6'h21: return "ADDU";
        6'h22: return "SUB";   6'h23: return "SUBU";
        6'h24: return "AND";   6'h25: return "OR";
        6'h26: return "XOR";   6'h27: return "NOR";
        6'h2A: return "SLT";   6'h00: return "SLL";
        6'h02: return "SRL";   6'h03: return "SRA";
        6'h04: return "SLLV";  6'h06: return "SRLV";
        6'h07: return "SRAV";
        default: return "BAD";
      endcase
    end
    case (opc)
      6'h08: return "ADDI";  6'h09: return "ADDIU";
      6'h0A: return "SLTI";  6'h0C: return "ANDI";
      6'h0D: return "ORI";   6'h0E: return "XORI";
      6'h0F: return "LUI";
      default: return "BAD";
    endcase
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] i, input logic [31:0] rsv,
                                      input logic [31:0] rtv);
    ref_t r;
    string m;
    int unsigned amt;
    r = '0;
    m = mnem(i);
    if (m == "ADD" || m == "ADDU" || m == "ADDI" || m == "ADDIU") r.op = 5'b00001;
    else if (m == "SUB" || m == "SUBU")                          r.op = 5'b01001;
    else if (m == "SLT" || m == "SLTI")                          r.op = 5'b01010;
    else if (m == "AND" || m == "ANDI")                          r.op = 5'b00000;
    else if (m == "OR"  || m == "ORI")                           r.op = 5'b01000;
    else if (m == "XOR" || m == "XORI")                          r.op = 5'b11000;
    else if (m == "NOR")                                         r.op = 5'b10000;
    else if (m == "SRL" || m == "SRLV")                          r.op = 5'b00100;
    else if (m == "SRA" || m == "SRAV")                          r.op = 5'b01100;
    else if (m == "SLL" || m == "SLLV")                          r.op = 5'b10100;
    else if (m == "LUI")                                         r.op = 5'b11100;

    if (m == "BAD") begin
      r.op  = ILL_OP;
`ifdef ID_ILLEGAL_TRAP_EN
      r.ill = 1'b1;
`endif
      return r;
    end
    if (m == "SLL" || m == "SRL" || m == "SRA" || m == "SLLV" || m == "SRLV" || m == "SRAV") begin
      if (m == "SLL" || m == "SRL" || m == "SRA") amt = i[10:6];
      else begin amt = rsv % 32; r.use_rs = 1'b1; end
      r.a = (m == "SLL" || m == "SLLV") ? 32'(amt * 64) : 32'(amt);
      r.b = rtv;
      r.dst = i[15:11];
      r.use_rt = 1'b1;
    end else if (i[31:26] == 6'h00) begin
      r.a = rsv; r.b = rtv; r.dst = i[15:11];
      r.use_rs = 1'b1; r.use_rt = 1'b1;
    end else if (m == "LUI") begin
      r.b = {16'h0, i[15:0]};
      r.dst = i[20:16];
    end else begin
      r.a = rsv;
      r.b = (m == "ADDI" || m == "ADDIU" || m == "SLTI") ? {{16{i[15]}}, i[15:0]} : {16'h0, i[15:0]};
      r.dst = i[20:16];
      r.use_rs = 1'b1;
    end
    r.ov   = (m == "ADD" || m == "SUB" || m == "ADDI");
    r.wben = (r.dst != 0);
    return r;
  endfunction

  ref_t        m_out;
  logic        m_valid;
  logic [31:0] m_busy;
  logic        last_rdy;

  // One clock of stimulus: drive, check combinational outputs mid-cycle,
  // advance the model across the edge, then check registered outputs.
  task automatic step(input logic rst, input logic v, input logic [31:0] instr,
                      input logic ordy, input logic wbv, input logic [4:0] wba);
    ref_t d;
    logic hz, exp_rdy;
    reset = rst; in_valid = v; in_instr = instr;
    out_ready = ordy; wb_valid = wbv; wb_addr = wba;
    #3;
    d  = ref_decode(instr, regs[instr[25:21]], regs[instr[20:16]]);
    hz = (d.use_rs && m_busy[instr[25:21]]) || (d.use_rt && m_busy[instr[20:16]]);
    exp_rdy = !rst && (!m_valid || ordy) && !hz;
    chk("in_ready", in_ready, exp_rdy);
    chk("rf_raddr1", rf_raddr1, instr[25:21]);
    chk("rf_raddr2", rf_raddr2, instr[20:16]);
    last_rdy = in_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_out = '0; m_busy = '0;
    end else begin
      if (wbv) m_busy[wba] = 1'b0;
      if (v && exp_rdy) begin
        m_out = d; m_valid = 1'b1;
        if (d.wben) m_busy[d.dst] = 1'b1;
      end else if (ordy) m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("alu_op", alu_op, m_out.op);
    chk("alu_a", alu_a, m_out.a);
    chk("alu_b", alu_b, m_out.b);
    chk("wb_dst", wb_dst, m_out.dst);
    chk("wb_en", wb_en, m_out.wben);
    chk("ov_check", ov_check, m_out.ov);
`ifdef ID_ILLEGAL_TRAP_EN
    chk("dec_illegal", dec_illegal, m_out.ill);
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wben;
    logic        ov;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [16];
    logic [5:0] iop [9];
    logic [4:0] rs, rt, rd, sh;
    logic [31:0] imm;
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h02};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sh = 5'($urandom_range(0, 31));
    imm = $urandom;
    if ($urandom_range(0, 15) < 8)
      return {6'h00, rs, rt, rd, sh, rfn[$urandom_range(0, 15)]};
    return {iop[$urandom_range(0, 8)], rs, rt, imm[15:0]};
  endfunction

  localparam logic [31:0] ADDI_T0 = 32'h2008FFFF;
  localparam logic [31:0] ADD_T1  = 32'h01084820;  // ADD $t1,$t0,$t0

  initial begin
    logic [31:0] cur;
    logic        have, v, ordy, wbv, rst;
    logic [4:0]  wba;

    for (int i = 0; i < 32; i++) regs[i] = '0;
    m_out = '0; m_valid = 1'b0; m_busy = '0; last_rdy = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0;

    tbl[0]  = '{32'h2008FFFF, 32'h0, 32'h0, 5'b00001, 32'h0, 32'hFFFFFFFF, 5'd8, 1'b1, 1'b1};
    tbl[1]  = '{32'h000A4900, 32'h0, 32'h1, 5'b10100, 32'h100, 32'h1, 5'd9, 1'b1, 1'b0};
    tbl[2]  = '{32'h000A4903, 32'h0, 32'h1, 5'b01100, 32'h4, 32'h1, 5'd9, 1'b1, 1'b0};
    tbl[3]  = '{32'h00221820, 32'h5, 32'h7, 5'b00001, 32'h5, 32'h7, 5'd3, 1'b1, 1'b1};
    tbl[4]  = '{32'h00221823, 32'h5, 32'h7, 5'b01001, 32'h5, 32'h7, 5'd3, 1'b1, 1'b0};
    tbl[5]  = '{32'h00221827, 32'h5, 32'h7, 5'b10000, 32'h5, 32'h7, 5'd3, 1'b1, 1'b0};
    tbl[6]  = '{32'h2824FFFE, 32'h5, 32'h0, 5'b01010, 32'h5, 32'hFFFFFFFE, 5'd4, 1'b1, 1'b0};
    tbl[7]  = '{32'h34248001, 32'h5, 32'h0, 5'b01000, 32'h5, 32'h00008001, 5'd4, 1'b1, 1'b0};
    tbl[8]  = '{32'h3C051234, 32'h0, 32'h0, 5'b11100, 32'h0, 32'h00001234, 5'd5, 1'b1, 1'b0};
    tbl[9]  = '{32'h00223004, 32'hFFFFFFE5, 32'h7, 5'b10100, 32'h140, 32'h7, 5'd6, 1'b1, 1'b0};
    tbl[10] = '{32'h00223006, 32'hFFFFFFE5, 32'h7, 5'b00100, 32'h5, 32'h7, 5'd6, 1'b1, 1'b0};
    tbl[11] = '{32'h00000000, 32'h0, 32'h0, 5'b10100, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[12] = '{32'h24278000, 32'h5, 32'h0, 5'b00001, 32'h5, 32'hFFFF8000, 5'd7, 1'b1, 1'b0};
    tbl[13] = '{32'h00220026, 32'h5, 32'h7, 5'b11000, 32'h5, 32'h7, 5'd0, 1'b0, 1'b0};
    tbl[14] = '{32'hFC000000, 32'h0, 32'h0, ILL_OP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl[15] = '{32'h00200008, 32'h5, 32'h0, ILL_OP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};

    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("reset_out_valid", out_valid, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);

    foreach (tbl[k]) begin
      regs[tbl[k].instr[25:21]] = tbl[k].rsv;
      regs[tbl[k].instr[20:16]] = tbl[k].rtv;
      step(1'b0, 1'b1, tbl[k].instr, 1'b1, 1'b0, '0);
      chk("tbl_accept", last_rdy, 1'b1);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_op", alu_op, tbl[k].op);
      chk("tbl_a", alu_a, tbl[k].a);
      chk("tbl_b", alu_b, tbl[k].b);
      chk("tbl_dst", wb_dst, tbl[k].dst);
      chk("tbl_wben", wb_en, tbl[k].wben);
      chk("tbl_ov", ov_check, tbl[k].ov);
`ifdef ID_ILLEGAL_TRAP_EN
      chk("tbl_illegal", dec_illegal, (k >= 14) ? 1'b1 : 1'b0);
`endif
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, tbl[k].dst);
    end

    // RAW hazard on $t0; clearing an unrelated register or same-cycle clear
    // of $t0 must not release the stall.
    step(1'b0, 1'b1, ADDI_T0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, ADD_T1, 1'b1, 1'b1, 5'd9);
    chk("haz_stall_wb9", last_rdy, 1'b0);
    step(1'b0, 1'b1, ADD_T1, 1'b1, 1'b0, '0);
    chk("haz_stall", last_rdy, 1'b0);
    step(1'b0, 1'b1, ADD_T1, 1'b1, 1'b1, 5'd8);
    chk("haz_same_cycle_clear", last_rdy, 1'b0);
    step(1'b0, 1'b1, ADD_T1, 1'b1, 1'b0, '0);
    chk("haz_release", last_rdy, 1'b1);
    chk("haz_dst", wb_dst, 5'd9);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd9);

    // Backpressure: bundle held three cycles, then same-cycle accept.
    step(1'b0, 1'b1, 32'h34248001, 1'b0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 32'h3C051234, 1'b0, 1'b0, '0);
      chk("bp_stall", last_rdy, 1'b0);
      chk("bp_hold_b", alu_b, 32'h00008001);
      chk("bp_hold_op", alu_op, 5'b01000);
    end
    step(1'b0, 1'b1, 32'h3C051234, 1'b1, 1'b0, '0);
    chk("bp_release", last_rdy, 1'b1);
    chk("bp_next_op", alu_op, 5'b11100);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd4);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd5);

    // Reset while holding a bundle with $t0 busy.
    step(1'b0, 1'b1, ADDI_T0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, ADD_T1, 1'b0, 1'b0, '0);
    chk("rst_in_ready", last_rdy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    step(1'b0, 1'b1, ADD_T1, 1'b1, 1'b0, '0);
    chk("rst_no_stall", last_rdy, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd9);

    // Randomized phase.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    have = 1'b0;
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      if (!have) begin cur = rand_instr(); have = 1'b1; end
      v    = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 7);
      wbv  = ($urandom_range(0, 9) < 4);
      wba  = 5'($urandom_range(0, 7));
      rst  = ($urandom_range(0, 199) == 0);
      step(rst, v, cur, ordy, wbv, wba);
      if (v && last_rdy && !rst) have = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
